// File: rtl/hazard_unit_pkg.sv
// Shared constants and types for the load-use / branch hazard unit.
// The steering word bundles the six pipeline control outputs so each case is a single assignment.
package hazard_unit_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_STALL = 1'b1;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic risk;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
  } steer_t;

  function automatic steer_t steer_run();
    steer_t s;
    s = '0;
    s.pc_write    = 1'b1;
    s.if_id_write = 1'b1;
    return s;
  endfunction

  // A bubble and the reset condition steer the pipeline the same way.
  function automatic steer_t steer_bubble();
    steer_t s;
    s      = '0;
    s.risk = 1'b1;
    return s;
  endfunction

  function automatic steer_t steer_flush();
    return '1;
  endfunction

endpackage

// File: rtl/hazard_if.sv
// Pipeline-side bundle for the hazard unit: register fields in, steering and counters out.
// master = pipeline datapath, slave = hazard unit.
interface hazard_if import hazard_unit_pkg::*; #(
  parameter int CNT_W = 32
) ();

  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rt;
  logic             ex_MemRead;
  logic [REG_W-1:0] ex_rt;
  logic             mem_branch_taken;

  logic             pc_write;
  logic             if_id_write;
  logic             riskSig;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_MemRead, ex_rt, mem_branch_taken,
    input  pc_write, if_id_write, riskSig, if_id_flush, id_ex_flush, ex_mem_flush,
    input  stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_MemRead, ex_rt, mem_branch_taken,
    output pc_write, if_id_write, riskSig, if_id_flush, id_ex_flush, ex_mem_flush,
    output stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_perf_cnt.sv
// Free-running stall and flush event counters; wrap silently at 2^CNT_W.
module hazard_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_inc,
  input  logic             flush_inc,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_inc) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Load-use stall FSM and taken-branch flush steering for the 5-stage pipeline.
// LOAD_STALL_CYCLES must be 1..3; the remaining-bubble counter is 2 bits wide.
module hazard_unit import hazard_unit_pkg::*; #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 32
) (
  input  logic     clk,
  input  logic     rst,
  hazard_if.slave  hz
);

  localparam logic [1:0] REM_INIT = 2'(LOAD_STALL_CYCLES - 1);

  logic [0:0] state, state_nxt;
  logic [1:0] rem, rem_nxt;
  logic       lu;
  steer_t     steer;

  assign lu = hz.ex_MemRead && (hz.ex_rt != REG_ZERO) &&
              ((hz.ex_rt == hz.id_rs) || (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));

  // Branch beats an active stall: the stalled instructions are wrong-path anyway.
  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    steer     = steer_run();
    if (rst) begin
      steer = steer_bubble();
    end else if (hz.mem_branch_taken) begin
      steer     = steer_flush();
      state_nxt = ST_IDLE;
      rem_nxt   = 2'd0;
    end else if (state == ST_STALL) begin
      steer   = steer_bubble();
      rem_nxt = rem - 2'd1;
      if (rem <= 2'd1) state_nxt = ST_IDLE;
    end else if (lu) begin
      steer = steer_bubble();
      if (LOAD_STALL_CYCLES > 1) begin
        state_nxt = ST_STALL;
        rem_nxt   = REM_INIT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      rem   <= 2'd0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
    end
  end

  assign hz.pc_write     = steer.pc_write;
  assign hz.if_id_write  = steer.if_id_write;
  assign hz.riskSig      = steer.risk;
  assign hz.if_id_flush  = steer.if_id_flush;
  assign hz.id_ex_flush  = steer.id_ex_flush;
  assign hz.ex_mem_flush = steer.ex_mem_flush;

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_perf_cnt (
    .clk       (clk),
    .rst       (rst),
    .stall_inc (steer.risk && !hz.mem_branch_taken && !rst),
    .flush_inc (hz.mem_branch_taken && !rst),
    .stall_cnt (hz.stall_cnt),
    .flush_cnt (hz.flush_cnt)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: three instances (1/2/3 bubbles, one with 4-bit counters) share stimulus;
// a reference model pushes expected steering/counters per cycle, popped and compared at negedge.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_MemRead, mem_branch_taken;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_if #(.CNT_W(4))  hz1 ();
  hazard_if #(.CNT_W(32)) hz2 ();
  hazard_if #(.CNT_W(32)) hz3 ();

  assign hz1.id_rs = id_rs;  assign hz1.id_rt = id_rt;  assign hz1.id_uses_rt = id_uses_rt;
  assign hz1.ex_MemRead = ex_MemRead;  assign hz1.ex_rt = ex_rt;  assign hz1.mem_branch_taken = mem_branch_taken;
  assign hz2.id_rs = id_rs;  assign hz2.id_rt = id_rt;  assign hz2.id_uses_rt = id_uses_rt;
  assign hz2.ex_MemRead = ex_MemRead;  assign hz2.ex_rt = ex_rt;  assign hz2.mem_branch_taken = mem_branch_taken;
  assign hz3.id_rs = id_rs;  assign hz3.id_rt = id_rt;  assign hz3.id_uses_rt = id_uses_rt;
  assign hz3.ex_MemRead = ex_MemRead;  assign hz3.ex_rt = ex_rt;  assign hz3.mem_branch_taken = mem_branch_taken;

  hazard_unit #(.LOAD_STALL_CYCLES(1), .CNT_W(4))  dut1 (.clk(clk), .rst(rst), .hz(hz1));
  hazard_unit #(.LOAD_STALL_CYCLES(2), .CNT_W(32)) dut2 (.clk(clk), .rst(rst), .hz(hz2));
  hazard_unit #(.LOAD_STALL_CYCLES(3), .CNT_W(32)) dut3 (.clk(clk), .rst(rst), .hz(hz3));

  logic [5:0]  got_ctl [3];
  logic [31:0] got_sc  [3];
  logic [31:0] got_fc  [3];

  assign got_ctl[0] = {hz1.pc_write, hz1.if_id_write, hz1.riskSig, hz1.if_id_flush, hz1.id_ex_flush, hz1.ex_mem_flush};
  assign got_ctl[1] = {hz2.pc_write, hz2.if_id_write, hz2.riskSig, hz2.if_id_flush, hz2.id_ex_flush, hz2.ex_mem_flush};
  assign got_ctl[2] = {hz3.pc_write, hz3.if_id_write, hz3.riskSig, hz3.if_id_flush, hz3.id_ex_flush, hz3.ex_mem_flush};
  assign got_sc[0]  = {28'd0, hz1.stall_cnt};
  assign got_fc[0]  = {28'd0, hz1.flush_cnt};
  assign got_sc[1]  = hz2.stall_cnt;
  assign got_fc[1]  = hz2.flush_cnt;
  assign got_sc[2]  = hz3.stall_cnt;
  assign got_fc[2]  = hz3.flush_cnt;

  // {pc_write, if_id_write, riskSig, if_id_flush, id_ex_flush, ex_mem_flush}
  localparam logic [5:0] C_RUN    = 6'b110000;
  localparam logic [5:0] C_BUBBLE = 6'b001000;
  localparam logic [5:0] C_FLUSH  = 6'b111111;

  typedef struct packed {
    logic [2:0][5:0]  ctl;
    logic [2:0][31:0] sc;
    logic [2:0][31:0] fc;
  } exp_t;

  exp_t        sb_q [$];
  int          m_pend [3];
  logic [31:0] m_sc   [3];
  logic [31:0] m_fc   [3];
  int          m_len  [3] = '{1, 2, 3};
  logic [31:0] m_mask [3] = '{32'hF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle(input logic r, input logic mr, input logic [4:0] ert,
                       input logic [4:0] rs, input logic [4:0] rt, input logic urt, input logic br);
    exp_t e;
    exp_t o;
    logic lu_m;
    rst = r; ex_MemRead = mr; ex_rt = ert; id_rs = rs; id_rt = rt; id_uses_rt = urt; mem_branch_taken = br;
    lu_m = mr && (ert != 5'd0) && ((ert == rs) || (urt && (ert == rt)));
    for (int k = 0; k < 3; k++) begin
      if (r)                          e.ctl[k] = C_BUBBLE;
      else if (br)                    e.ctl[k] = C_FLUSH;
      else if (m_pend[k] > 0 || lu_m) e.ctl[k] = C_BUBBLE;
      else                            e.ctl[k] = C_RUN;
      e.sc[k] = m_sc[k];
      e.fc[k] = m_fc[k];
    end
    sb_q.push_back(e);
    @(negedge clk);
    o = sb_q.pop_front();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("ctl_L%0d", k + 1), {58'd0, got_ctl[k]}, {58'd0, o.ctl[k]});
      chk($sformatf("stall_cnt_L%0d", k + 1), {32'd0, got_sc[k]}, {32'd0, o.sc[k]});
      chk($sformatf("flush_cnt_L%0d", k + 1), {32'd0, got_fc[k]}, {32'd0, o.fc[k]});
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (r) begin
        m_pend[k] = 0; m_sc[k] = '0; m_fc[k] = '0;
      end else if (br) begin
        m_pend[k] = 0; m_fc[k] = (m_fc[k] + 1) & m_mask[k];
      end else if (m_pend[k] > 0) begin
        m_pend[k]--; m_sc[k] = (m_sc[k] + 1) & m_mask[k];
      end else if (lu_m) begin
        m_pend[k] = m_len[k] - 1; m_sc[k] = (m_sc[k] + 1) & m_mask[k];
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_pend[k] = 0; m_sc[k] = '0; m_fc[k] = '0;
    end
    rst = 1'b1; ex_MemRead = 1'b0; ex_rt = '0; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; mem_branch_taken = 1'b0;
    @(posedge clk); #1;
    do_reset();
    idle(2);

    // Single load-use on rs
    cycle(1'b0, 1'b1, 5'd8, 5'd8, 5'd3, 1'b0, 1'b0);
    idle(4);
    chk("lu_rs_sc_L1", {32'd0, got_sc[0]}, 64'd1);
    chk("lu_rs_sc_L2", {32'd0, got_sc[1]}, 64'd2);
    chk("lu_rs_sc_L3", {32'd0, got_sc[2]}, 64'd3);

    // Load-use on rt; load leaves EX after the first bubble
    do_reset();
    cycle(1'b0, 1'b1, 5'd9, 5'd1, 5'd9, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 5'd0, 5'd1, 5'd9, 1'b1, 1'b0);
    idle(3);
    chk("lu_rt_sc_L2", {32'd0, got_sc[1]}, 64'd2);

    // $zero destination and unused rt never stall
    do_reset();
    cycle(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0);
    idle(1);
    chk("no_stall_sc_L3", {32'd0, got_sc[2]}, 64'd0);

    // Branch in the second bubble cycle of a stall
    do_reset();
    cycle(1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1);
    idle(2);
    chk("br_stall_sc_L3", {32'd0, got_sc[2]}, 64'd1);
    chk("br_stall_fc_L3", {32'd0, got_fc[2]}, 64'd1);

    // Load-use and branch together in IDLE
    do_reset();
    cycle(1'b0, 1'b1, 5'd7, 5'd7, 5'd7, 1'b1, 1'b1);
    idle(3);
    chk("lu_br_sc_L3", {32'd0, got_sc[2]}, 64'd0);
    chk("lu_br_fc_L3", {32'd0, got_fc[2]}, 64'd1);

    // Reset in the middle of a stall with nonzero counters
    cycle(1'b0, 1'b1, 5'd4, 5'd4, 5'd0, 1'b0, 1'b0);
    do_reset();
    idle(2);
    chk("rst_stall_sc_L3", {32'd0, got_sc[2]}, 64'd0);
    chk("rst_stall_fc_L3", {32'd0, got_fc[2]}, 64'd0);

    // Counter wrap on the 4-bit instance
    do_reset();
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b1, 5'd6, 5'd6, 5'd0, 1'b0, 1'b0);
    idle(1);
    chk("wrap_sc_L1", {32'd0, got_sc[0]}, 64'd4);

    // Random traffic
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 149) == 0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            $urandom_range(0, 7) == 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
